// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and default widths for the compare/dead-time stage.
package pwm_pkg;
    typedef enum logic [2:0] {IDLE, HI, DEAD_TO_LO, LO, DEAD_TO_HI} pwm_state_t;
    localparam int PWM_BIT_WIDTH_DEF = 16;
    localparam int PWM_DT_WIDTH_DEF = 8;
endpackage

// File: rtl/pwm_compare_deadtime_deadtime_insert.sv
// deadtime_insert: complementary gate FSM with dead counter; PWM_FAULT_LATCH_EN adds a fault latch.
module deadtime_insert
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = PWM_DT_WIDTH_DEF
) (
    input  logic                MClk,
    input  logic                Rst,
    input  logic                En,
    input  logic                raw,
    input  logic [DT_WIDTH-1:0] DeadTime,
`ifdef PWM_FAULT_LATCH_EN
    input  logic                Fault,
    input  logic                FaultClr,
    output logic                Faulted,
`endif
    output logic                PwmH,
    output logic                PwmL
);
    pwm_state_t state, state_n;
    logic [DT_WIDTH-1:0] cnt, cnt_n;
    logic hold, dt_zero, cnt_one;
    assign dt_zero = DeadTime == '0;
    assign cnt_one = cnt == DT_WIDTH'(1);
`ifdef PWM_FAULT_LATCH_EN
    always_ff @(posedge MClk) begin
        if (Rst) Faulted <= 1'b0;
        else if (Fault) Faulted <= 1'b1;
        else if (FaultClr) Faulted <= 1'b0;
    end
    assign hold = ~En | Fault | (Faulted & ~FaultClr);
`else
    assign hold = ~En;
`endif
    always_ff @(posedge MClk) begin
        if (Rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end
    // A dead window that sees raw revert returns straight to the side it came from.
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        if (hold) begin
            state_n = IDLE;
            cnt_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = dt_zero ? (raw ? HI : LO) : (raw ? DEAD_TO_HI : DEAD_TO_LO);
                    cnt_n = DeadTime;
                end
                HI: if (!raw) begin
                    state_n = dt_zero ? LO : DEAD_TO_LO;
                    cnt_n = DeadTime;
                end
                LO: if (raw) begin
                    state_n = dt_zero ? HI : DEAD_TO_HI;
                    cnt_n = DeadTime;
                end
                DEAD_TO_LO: begin
                    state_n = raw ? HI : (cnt_one ? LO : DEAD_TO_LO);
                    cnt_n = (raw || cnt_one) ? '0 : cnt - DT_WIDTH'(1);
                end
                DEAD_TO_HI: begin
                    state_n = !raw ? LO : (cnt_one ? HI : DEAD_TO_HI);
                    cnt_n = (!raw || cnt_one) ? '0 : cnt - DT_WIDTH'(1);
                end
                default: begin
                    state_n = IDLE;
                    cnt_n = '0;
                end
            endcase
        end
    end
    always_comb begin
        PwmH = state == HI;
        PwmL = state == LO;
    end
endmodule

// File: rtl/pwm_compare_deadtime.sv
// pwm_compare_deadtime: carrier compare with valley-synchronised duty and dead-time gate drives.
// Optional fault latch ports/logic when PWM_FAULT_LATCH_EN is defined.
module pwm_compare_deadtime
    import pwm_pkg::*;
#(
    parameter int BIT_WIDTH = PWM_BIT_WIDTH_DEF,
    parameter int DT_WIDTH  = PWM_DT_WIDTH_DEF
) (
    input  logic                 MClk,
    input  logic                 Rst,
    input  logic                 En,
    input  logic [BIT_WIDTH-1:0] TWave,
    input  logic [BIT_WIDTH-1:0] LowerLimit,
    input  logic [BIT_WIDTH-1:0] DutyCmp,
    input  logic                 DutyWr,
    input  logic [DT_WIDTH-1:0]  DeadTime,
`ifdef PWM_FAULT_LATCH_EN
    input  logic                 Fault,
    input  logic                 FaultClr,
    output logic                 Faulted,
`endif
    output logic                 PwmH,
    output logic                 PwmL,
    output logic [BIT_WIDTH-1:0] DutyActive
);
    logic [BIT_WIDTH-1:0] tw_q, shadow;
    logic pending, raw_q, valley;
    assign valley = tw_q <= LowerLimit;
    // A write landing in a valley cycle bypasses the shadow entirely.
    always_ff @(posedge MClk) begin
        if (Rst) begin
            tw_q <= '0;
            raw_q <= 1'b0;
            shadow <= '0;
            pending <= 1'b0;
            DutyActive <= '0;
        end else begin
            tw_q <= TWave;
            raw_q <= tw_q < DutyActive;
            if (DutyWr) shadow <= DutyCmp;
            DutyActive <= (DutyWr && valley) ? DutyCmp : (valley && pending) ? shadow : DutyActive;
            pending <= DutyWr ? !valley : pending && !valley;
        end
    end
    deadtime_insert #(.DT_WIDTH(DT_WIDTH)) u_dt (
        .MClk     (MClk),
        .Rst      (Rst),
        .En       (En),
        .raw      (raw_q),
        .DeadTime (DeadTime),
`ifdef PWM_FAULT_LATCH_EN
        .Fault    (Fault),
        .FaultClr (FaultClr),
        .Faulted  (Faulted),
`endif
        .PwmH     (PwmH),
        .PwmL     (PwmL)
    );
endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// tb_pwm_compare_deadtime: randomized scoreboard bench against a cycle-level behavioural model.
module tb_pwm_compare_deadtime;
    logic        MClk, Rst, En, DutyWr, PwmH, PwmL;
    logic [15:0] TWave, LowerLimit, DutyCmp, DutyActive;
    logic [7:0]  DeadTime;

    pwm_compare_deadtime dut (
        .MClk(MClk), .Rst(Rst), .En(En), .TWave(TWave), .LowerLimit(LowerLimit),
        .DutyCmp(DutyCmp), .DutyWr(DutyWr), .DeadTime(DeadTime),
        .PwmH(PwmH), .PwmL(PwmL), .DutyActive(DutyActive)
    );

    initial MClk = 0;
    always #5 MClk = ~MClk;

    typedef struct {logic h; logic l; logic [15:0] da;} exp_t;
    exp_t exp_q[$];
    int checks = 0, errors = 0, cyc_n = 0;

    // model: drive 0=none 1=high 2=low; tgt = side awaited after dead time (0 = not in dead window)
    int m_tw = 0, m_raw = 0, m_da = 0, m_sh = 0, m_pend = 0, m_drv = 0, m_tgt = 0, m_left = 0;
    int g_tw = 250, g_dir = 1;

    task automatic model_edge();
        int n_raw, want, valley;
        if (Rst) begin
            m_tw = 0; m_raw = 0; m_da = 0; m_sh = 0; m_pend = 0; m_drv = 0; m_tgt = 0; m_left = 0;
        end else begin
            n_raw = (m_tw < m_da) ? 1 : 0;
            valley = (m_tw <= int'(LowerLimit)) ? 1 : 0;
            want = m_raw ? 1 : 2;
            if (DutyWr && valley) begin m_da = DutyCmp; m_pend = 0; end
            else if (DutyWr) begin m_sh = DutyCmp; m_pend = 1; end
            else if (valley && m_pend) begin m_da = m_sh; m_pend = 0; end
            if (!En) begin
                m_drv = 0; m_tgt = 0; m_left = 0;
            end else if (m_tgt != 0) begin
                if (want != m_tgt) begin m_drv = want; m_tgt = 0; end
                else if (m_left == 1) begin m_drv = m_tgt; m_tgt = 0; end
                else m_left--;
            end else if (m_drv != want) begin
                if (DeadTime == 0) m_drv = want;
                else begin m_drv = 0; m_tgt = want; m_left = DeadTime; end
            end
            m_raw = n_raw;
            m_tw = TWave;
        end
        exp_q.push_back('{h: m_drv == 1, l: m_drv == 2, da: 16'(m_da)});
    endtask

    task automatic cyc(input int mode);
        g_tw += 3 * g_dir;
        if (g_tw >= 500) begin g_tw = 500; g_dir = -1; end
        if (g_tw <= 250) begin g_tw = 250; g_dir = 1; end
        TWave = (mode == 0) ? 16'(g_tw) : 16'(m_da + int'($urandom_range(0, 6)) - 3);
        model_edge();
        @(negedge MClk);
        DutyWr = 0;
        cyc_n++;
    endtask

    task automatic wr(input int v);
        DutyCmp = 16'(v);
        DutyWr = 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc_n, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge MClk);
            #1;
            chk("overlap", int'(PwmH && PwmL), 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("PwmH", int'(PwmH), int'(e.h));
                chk("PwmL", int'(PwmL), int'(e.l));
                chk("DutyActive", int'(DutyActive), int'(e.da));
            end
        end
    end

    initial begin
        Rst = 1; En = 0; TWave = 0; LowerLimit = 250; DutyCmp = 0; DutyWr = 0; DeadTime = 10;
        repeat (3) cyc(0);
        Rst = 0; En = 1;
        wr(375); cyc(0);
        repeat (400) cyc(0);
        for (int i = 0; i < 200 && !(g_dir == 1 && g_tw > 350); i++) cyc(0);
        wr(300); cyc(0);
        repeat (300) cyc(0);
        for (int i = 0; i < 200 && m_tw > 250; i++) cyc(0);
        wr(420); cyc(0);
        repeat (200) cyc(0);
        DeadTime = 0;
        repeat (400) cyc(0);
        DeadTime = 3;
        wr(0); cyc(0);
        repeat (250) cyc(0);
        wr(600); cyc(0);
        repeat (250) cyc(0);
        DeadTime = 6;
        wr(400); cyc(0);
        repeat (200) cyc(0);
        repeat (300) cyc(1);
        for (int b = 0; b < 30; b++) begin
            int mode;
            mode = ($urandom_range(0, 2) == 0) ? 1 : 0;
            for (int i = 0; i < 100; i++) begin
                Rst = ($urandom_range(0, 149) == 0);
                En = ($urandom_range(0, 59) != 0);
                if ($urandom_range(0, 49) == 0) wr(int'($urandom_range(0, 560)));
                if ($urandom_range(0, 99) == 0) DeadTime = 8'($urandom_range(0, 12));
                cyc(mode);
            end
        end
        Rst = 0; En = 1;
        repeat (5) cyc(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
